// File: rtl/async_fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// async_fifo_arb_pkg
// Shared types and helpers for the asynchronous FIFO write-side scheduler.
//   arb_state_e : arbiter FSM encoding (ARB_IDLE / ARB_LOCK)
//   STAT_WIDTH  : width of each optional statistics counter
//   STAT_MAX    : saturation value of a statistics counter
//   sat_inc()   : saturating increment used by the statistics counters
// Also supplies a default for the DATA_WIDTH macro when the build has none.
// -----------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package async_fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  localparam int STAT_WIDTH = 16;
  localparam int STAT_MAX   = 2**STAT_WIDTH - 1;

  // Counter increment that sticks at STAT_MAX instead of wrapping.
  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] value);
    return (value == STAT_WIDTH'(STAT_MAX)) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/async_fifo_rr_picker.sv
// -----------------------------------------------------------------------------
// async_fifo_rr_picker
// Purely combinational round-robin picker: returns the first set bit of the
// request vector at or after the pointer, wrapping modulo NUM_REQ.
// Shared by the write-side and read-side schedulers.
// Ports:
//   i_req    [NUM_REQ]          request vector
//   i_rr_ptr [$clog2(NUM_REQ)]  search start index (highest priority)
//   o_found  [1]                at least one request is set
//   o_idx    [$clog2(NUM_REQ)]  selected index (0 when nothing is found)
// -----------------------------------------------------------------------------
module async_fifo_rr_picker
  import async_fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_rr_ptr,
  output logic                       o_found,
  output logic [$clog2(NUM_REQ)-1:0] o_idx
);

  localparam int IDW = $clog2(NUM_REQ);

  // Scan from the farthest position back to the pointer so that the
  // candidate nearest the pointer is the last (winning) assignment.
  always_comb begin : pick_proc
    logic [IDW-1:0] pos;
    pos     = {IDW{1'b0}};
    o_idx   = {IDW{1'b0}};
    o_found = |i_req;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos   = IDW'((int'(i_rr_ptr) + k) % NUM_REQ);
      o_idx = i_req[pos] ? pos : o_idx;
    end
  end

endmodule

// File: rtl/async_fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// async_fifo_write_arbiter
// Shares the single write port of the asynchronous FIFO among NUM_REQ
// requesters using round-robin arbitration with burst locking. A granted
// requester writes up to MAX_BURST words; write_full is honoured so the FIFO
// never overflows. Everything runs on posedge write_clk.
// Ports:
//   write_clk, write_rst          clock, synchronous active-high reset
//   req_valid/req_last [NUM_REQ]  per-requester word valid / final word
//   req_data [NUM_REQ*DATA_WIDTH] packed data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready [NUM_REQ]           per-requester accept
//   write_en/write_data           FIFO write pins (combinational from handshake)
//   write_full                    FIFO full flag
//   grant_valid/grant_id          current port owner
// Optional (macro ASYNC_FIFO_ARB_STATS_EN):
//   stat_words [NUM_REQ*16]       saturating per-requester transfer counters
//   stat_stall [16]               saturating count of full-stalled lock cycles
// -----------------------------------------------------------------------------
module async_fifo_write_arbiter
  import async_fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int MAX_BURST  = 4
) (
  input  logic                            write_clk,
  input  logic                            write_rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            write_en,
  output logic [DATA_WIDTH-1:0]           write_data,
  input  logic                            write_full,
  output logic                            grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id
`ifdef ASYNC_FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_WIDTH-1:0]   stat_words,
  output logic [STAT_WIDTH-1:0]           stat_stall
`endif
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(MAX_BURST + 1);

  arb_state_e       r_state;
  logic [IDW-1:0]   r_owner;
  logic [IDW-1:0]   r_rr_ptr;
  logic [CW-1:0]    r_burst_cnt;

  logic                  w_found;
  logic [IDW-1:0]        w_pick_idx;
  logic                  w_lock;
  logic                  w_own_valid;
  logic                  w_xfer;
  logic                  w_burst_end;
  logic [IDW-1:0]        w_next_ptr;
  logic [DATA_WIDTH-1:0] w_own_data;

  async_fifo_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .i_req    (req_valid),
    .i_rr_ptr (r_rr_ptr),
    .o_found  (w_found),
    .o_idx    (w_pick_idx)
  );

  assign w_lock      = (r_state == ARB_LOCK);
  assign w_own_valid = req_valid[r_owner];
  assign w_own_data  = req_data[r_owner*DATA_WIDTH +: DATA_WIDTH];
  // Reset gates the transfer so no word is written in the reset cycle.
  assign w_xfer      = w_lock & w_own_valid & ~write_full & ~write_rst;
  assign w_burst_end = req_last[r_owner] | (r_burst_cnt == CW'(MAX_BURST - 1));
  assign w_next_ptr  = (r_owner == IDW'(NUM_REQ - 1)) ? {IDW{1'b0}} : r_owner + IDW'(1);

  // Handshake and FIFO-pin outputs, derived from the lock state and owner.
  always_comb begin
    req_ready = {NUM_REQ{1'b0}};
    if (w_lock && !write_full && !write_rst) begin
      req_ready[r_owner] = 1'b1;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
    write_en    = w_xfer;
    write_data  = w_xfer ? w_own_data : {DATA_WIDTH{1'b0}};
    grant_valid = w_lock;
    grant_id    = w_lock ? r_owner : {IDW{1'b0}};
  end

  // Arbiter FSM: pick an owner in IDLE, stream its burst in LOCK.
  always_ff @(posedge write_clk) begin
    if (write_rst) begin
      r_state     <= ARB_IDLE;
      r_owner     <= {IDW{1'b0}};
      r_rr_ptr    <= {IDW{1'b0}};
      r_burst_cnt <= {CW{1'b0}};
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_found) begin
            r_owner     <= w_pick_idx;
            r_burst_cnt <= {CW{1'b0}};
            r_state     <= ARB_LOCK;
          end
        end
        ARB_LOCK: begin
          // A valid drop releases even while full; full alone only holds.
          if (!w_own_valid || (w_xfer && w_burst_end)) begin
            r_state     <= ARB_IDLE;
            r_rr_ptr    <= w_next_ptr;
            r_burst_cnt <= {CW{1'b0}};
          end else if (w_xfer) begin
            r_burst_cnt <= r_burst_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

`ifdef ASYNC_FIFO_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] r_stat_words [NUM_REQ];
  logic [STAT_WIDTH-1:0] r_stat_stall;

  // Saturating transfer and stall counters.
  always_ff @(posedge write_clk) begin
    if (write_rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_stat_words[i] <= {STAT_WIDTH{1'b0}};
      end
      r_stat_stall <= {STAT_WIDTH{1'b0}};
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_xfer && (r_owner == IDW'(i))) begin
          r_stat_words[i] <= sat_inc(r_stat_words[i]);
        end
      end
      if (w_lock && w_own_valid && write_full) begin
        r_stat_stall <= sat_inc(r_stat_stall);
      end
    end
  end

  // Pack the per-requester counters onto the flat output port.
  always_comb begin
    stat_words = {(NUM_REQ*STAT_WIDTH){1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_words[i*STAT_WIDTH +: STAT_WIDTH] = r_stat_words[i];
    end
    stat_stall = r_stat_stall;
  end
`endif

endmodule

// File: doc/async_fifo_write_arbiter.md
Name: async_fifo_write_arbiter

Overview:
Write-side scheduler that shares the single write port of the asynchronous FIFO among NUM_REQ requesters. It uses round-robin arbitration with burst locking, so each granted requester writes up to MAX_BURST contiguous words. It honours write_full so the FIFO never overflows. It sits entirely in the write_clk domain, between the producers and the FIFO's write_en, write_data and write_full pins.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH, `DATA_WIDTH, FIFO write data width
MAX_BURST, 4, maximum words per grant (1..256)

Ports:
write_clk  input  1  write-domain clock; all logic on posedge
write_rst  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester word valid
req_data  input  NUM_REQ*DATA_WIDTH  packed per-requester data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
req_last  input  NUM_REQ  marks the final word of a requester's burst
req_ready  output  NUM_REQ  per-requester accept
write_en  output  1  FIFO write enable
write_data  output  DATA_WIDTH  FIFO write data
write_full  input  1  FIFO full flag
grant_valid  output  1  a requester currently owns the port
grant_id  output  $clog2(NUM_REQ)  current owner index

Behaviour:
- Reset (synchronous, write_rst=1 at posedge):
  - state=ARB_IDLE, owner=0, rr_ptr=0, burst_cnt=0.
  - Outputs: req_ready=0, write_en=0, write_data=0, grant_valid=0, grant_id=0.
- Reset mid-burst aborts the burst. No write is issued in the reset cycle. Requester 0 has top priority afterwards.
- State ARB_IDLE:
  - req_ready=0, write_en=0.
  - If any req_valid is set, pick the first set bit searching rr_ptr, rr_ptr+1, ... (mod NUM_REQ).
  - Register that index as owner, clear burst_cnt, go to ARB_LOCK.
  - This costs a 1-cycle arbitration bubble per grant.
- State ARB_LOCK:
  - grant_valid=1, grant_id=owner.
  - req_ready[owner] = !write_full; all other req_ready bits are 0.
  - write_en = req_valid[owner] & !write_full, combinational; zero latency from the handshake to the FIFO pin.
  - write_data = req_data[owner] while write_en=1, else 0.
  - Transfer occurs when write_en=1: burst_cnt increments.
  - On a transfer with req_last[owner]=1 or burst_cnt==MAX_BURST-1, release.
- Release:
  - Go to ARB_IDLE with rr_ptr=(owner+1) mod NUM_REQ.
  - grant_valid falls in the next cycle.
- Owner deasserts req_valid while in ARB_LOCK: release at that posedge with the same rr_ptr update. Burst integrity is the requester's responsibility.
- write_full=1 in ARB_LOCK:
  - Hold the grant; no transfer; burst_cnt is frozen; the lock is kept even when write_full stays high indefinitely.
  - The write_full-held case does not count as a valid drop; release on valid drop still applies.
- Rotation: a requester that has just released has lowest priority in the next arbitration. No requester waits more than NUM_REQ-1 grants.
- req_last is ignored when no transfer occurs.
- burst_cnt width is $clog2(MAX_BURST+1). It never exceeds MAX_BURST-1.

Optional Feature:
Macro: ASYNC_FIFO_ARB_STATS_EN
- Defined: adds output stat_words (NUM_REQ*16), one 16-bit counter per requester.
  - Counter i increments on each transfer by requester i and saturates at 16'hFFFF.
- Defined: adds output stat_stall (16 bits), counting ARB_LOCK cycles with req_valid[owner]=1 and write_full=1; saturating.
- All counters clear on write_rst.
- Not defined: neither port exists, and no counter logic is synthesised.

Decomposition:
- Package async_fifo_arb_pkg holds:
  - typedef enum logic [0:0] arb_state_e {ARB_IDLE, ARB_LOCK}
  - localparam STAT_WIDTH=16
  - localparam STAT_MAX = 2**STAT_WIDTH-1
- Sub-module async_fifo_rr_picker: purely combinational.
  - Inputs: req vector and rr_ptr.
  - Outputs: found and idx (first set bit at or after the pointer, with wrap).
  - Reusable by the read-side scheduler.

Test Plan:
- Reset then req_valid=4'b0001, req_last on the 3rd word, data A0,A1,A2:
  - grant_id=0 one cycle after valid rises.
  - write_en high for 3 consecutive cycles, writing A0,A1,A2.
  - Then ARB_IDLE, with rr_ptr=1.
- All four requesters valid, no last, MAX_BURST=4:
  - Grants in order 0,1,2,3,0, with 4 writes each.
  - 1 idle cycle between grants.
  - 20 writes in 25 cycles.
- Owner 2 mid-burst and write_full asserted for 5 cycles:
  - req_ready[2]=0 and write_en=0 for those 5 cycles.
  - burst_cnt unchanged; grant_id stays 2.
  - Writing resumes the cycle write_full falls.
- Owner 1 drops req_valid after 2 words while requester 3 is valid:
  - ARB_IDLE next cycle, then grant to 3.
  - No write is issued in the drop cycle.
- write_rst pulsed while owner 3 is mid-burst:
  - All outputs 0 the following cycle.
  - With requesters 0 and 3 valid afterwards, requester 0 is granted first.
- With ASYNC_FIFO_ARB_STATS_EN defined and 70000 transfers from requester 0:
  - stat_words[15:0]=16'hFFFF and stays there.
  - Other counters are 0.
